// File: rtl/div_pkg.sv
// Shared definitions for the non-restoring division control unit.
//   - ALU opcodes driven on alu_op
//   - bank input-mux select codes driven on in_mux_add
//   - register-bank indices used by the micro-program
//   - controller state enumeration and the decoded control word
package div_pkg;

  // ALU opcodes
  localparam logic [2:0] PASS_A = 3'd0;
  localparam logic [2:0] PASS_B = 3'd1;
  localparam logic [2:0] ADD    = 3'd2;
  localparam logic [2:0] SUB    = 3'd3;
  localparam logic [2:0] SHL    = 3'd4;
  localparam logic [2:0] INC    = 3'd5;

  // Bank input-mux selects
  localparam logic [2:0] MUX_INA   = 3'd0;
  localparam logic [2:0] MUX_INB   = 3'd1;
  localparam logic [2:0] MUX_CONST = 3'd2;
  localparam logic [2:0] MUX_ALU   = 3'd3;
  localparam logic [2:0] MUX_BANK  = 3'd4;

  // Register-bank indices
  localparam logic [3:0] R_ALUA = 4'd1;
  localparam logic [3:0] R_ALUB = 4'd2;
  localparam logic [3:0] R_Q    = 4'd3;
  localparam logic [3:0] R_REM  = 4'd7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_A,
    ST_LD_B,
    ST_CHK,
    ST_DZ,
    ST_Q_LD,
    ST_Q_SHL,
    ST_A_LD,
    ST_A_SHL,
    ST_A_LD2,
    ST_OP,
    ST_Q_LD2,
    ST_QBIT,
    ST_R_LD,
    ST_R_ADD,
    ST_DONE
  } state_e;

  // One micro-instruction worth of datapath controls
  typedef struct packed {
    logic       we;
    logic [3:0] reg_add;
    logic [2:0] in_mux;
    logic [3:0] out_mux;
    logic [7:0] cnst;
    logic [2:0] alu_op;
    logic       alu_cin;
  } ctrl_t;

endpackage

// File: rtl/div_control_unit.sv
// Microprogrammed controller for an 8-bit by 7-bit non-restoring divider.
// Quotient ends in R3, remainder in R7.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a division (sampled only in IDLE)
//   alu_n, alu_z, alu_c   ALU status: sign, zero, shifted-out bit
//   in_mux_add, cu_const  bank input select and constant
//   we, reg_add           bank write enable / address
//   out_mux_add           bank read-port address
//   alu_op, alu_cin       ALU opcode and shift-in bit
//   busy, done, div_zero  status
module div_control_unit
  import div_pkg::*;
#(
  parameter int         ITER     = 8,
  parameter logic [3:0] IDLE_REG = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  output logic [2:0] in_mux_add,
  output logic [7:0] cu_const,
  output logic       we,
  output logic [3:0] reg_add,
  output logic [3:0] out_mux_add,
  output logic [2:0] alu_op,
  output logic       alu_cin,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);

  localparam int CNT_W = $clog2(ITER + 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             q_msb_reg;
  logic             a_neg_reg;
  logic             div_zero_reg;
  ctrl_t            ctrl;

  // Micro-op decoder. Non-writing states park the address on IDLE_REG so a
  // stale write enable downstream can only hit the unused register.
  function automatic ctrl_t decode(input state_e s, input logic a_neg_i,
                                   input logic q_msb_i);
    ctrl_t c;
    c.we      = 1'b0;
    c.reg_add = IDLE_REG;
    c.in_mux  = MUX_INA;
    c.out_mux = 4'd0;
    c.cnst    = 8'h00;
    c.alu_op  = PASS_A;
    c.alu_cin = 1'b0;
    case (s)
      ST_LD_A: begin
        c.we = 1'b1; c.reg_add = R_Q; c.in_mux = MUX_INA;
      end
      ST_LD_B: begin
        c.we = 1'b1; c.reg_add = R_ALUB; c.in_mux = MUX_INB;
      end
      ST_CHK: begin
        // PASS_B exposes the divisor on the zero flag
        c.we = 1'b1; c.reg_add = R_REM; c.in_mux = MUX_CONST;
        c.cnst = 8'h00; c.alu_op = PASS_B;
      end
      ST_DZ: begin
        c.we = 1'b1; c.reg_add = R_Q; c.in_mux = MUX_CONST; c.cnst = 8'hFF;
      end
      ST_Q_LD, ST_Q_LD2: begin
        c.we = 1'b1; c.reg_add = R_ALUA; c.in_mux = MUX_BANK; c.out_mux = R_Q;
      end
      ST_A_LD, ST_A_LD2, ST_R_LD: begin
        c.we = 1'b1; c.reg_add = R_ALUA; c.in_mux = MUX_BANK; c.out_mux = R_REM;
      end
      ST_Q_SHL: begin
        c.we = 1'b1; c.reg_add = R_Q; c.in_mux = MUX_ALU; c.alu_op = SHL;
      end
      ST_A_SHL: begin
        // Quotient MSB shifted out of Q enters the bottom of A
        c.we = 1'b1; c.reg_add = R_REM; c.in_mux = MUX_ALU; c.alu_op = SHL;
        c.alu_cin = q_msb_i;
      end
      ST_OP: begin
        c.we = 1'b1; c.reg_add = R_REM; c.in_mux = MUX_ALU;
        c.alu_op = a_neg_i ? ADD : SUB;
      end
      ST_QBIT: begin
        // Shifted Q has a zero LSB, so INC sets the new quotient bit
        if (!a_neg_i) begin
          c.we = 1'b1; c.reg_add = R_Q; c.in_mux = MUX_ALU; c.alu_op = INC;
        end
      end
      ST_R_ADD: begin
        c.we = 1'b1; c.reg_add = R_REM; c.in_mux = MUX_ALU; c.alu_op = ADD;
      end
      default: ;
    endcase
    return c;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_LD_A;
      ST_LD_A:  state_next = ST_LD_B;
      ST_LD_B:  state_next = ST_CHK;
      ST_CHK:   state_next = alu_z ? ST_DZ : ST_Q_LD;
      ST_DZ:    state_next = ST_DONE;
      ST_Q_LD:  state_next = ST_Q_SHL;
      ST_Q_SHL: state_next = ST_A_LD;
      ST_A_LD:  state_next = ST_A_SHL;
      ST_A_SHL: state_next = ST_A_LD2;
      ST_A_LD2: state_next = ST_OP;
      ST_OP:    state_next = ST_Q_LD2;
      ST_Q_LD2: state_next = ST_QBIT;
      ST_QBIT: begin
        if (cnt_reg == CNT_W'(1)) state_next = a_neg_reg ? ST_R_LD : ST_DONE;
        else                      state_next = ST_Q_LD;
      end
      ST_R_LD:  state_next = ST_R_ADD;
      ST_R_ADD: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Internal control flops: iteration counter and flag captures
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      q_msb_reg    <= 1'b0;
      a_neg_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE:  if (start) div_zero_reg <= 1'b0;
        ST_CHK: begin
          a_neg_reg    <= 1'b0;
          div_zero_reg <= 1'b0;
          cnt_reg      <= CNT_W'(ITER);
        end
        ST_DZ:    div_zero_reg <= 1'b1;
        ST_Q_SHL: q_msb_reg    <= alu_c;
        ST_OP:    a_neg_reg    <= alu_n;
        ST_QBIT:  cnt_reg      <= cnt_reg - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    ctrl        = decode(state_reg, a_neg_reg, q_msb_reg);
    we          = ctrl.we;
    reg_add     = ctrl.reg_add;
    in_mux_add  = ctrl.in_mux;
    out_mux_add = ctrl.out_mux;
    cu_const    = ctrl.cnst;
    alu_op      = ctrl.alu_op;
    alu_cin     = ctrl.alu_cin;
    busy        = (state_reg != ST_IDLE);
    done        = (state_reg == ST_DONE);
    div_zero    = div_zero_reg;
  end

endmodule

// File: tb/tb_div_control_unit.sv
// Bench for div_control_unit: a register bank + ALU environment around the
// controller, and an arithmetic model (a/b, a%b, latency from quotient parity)
// checked every cycle.
module tb_div_control_unit;
  import div_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       alu_n, alu_z, alu_c;
  logic [2:0] in_mux_add;
  logic [7:0] cu_const;
  logic       we;
  logic [3:0] reg_add, out_mux_add;
  logic [2:0] alu_op;
  logic       alu_cin, busy, done, div_zero;

  logic [7:0] in_a, in_b;
  logic [7:0] bank [16];
  logic [7:0] opa, opb, alu_out, bank_din, rd_port;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state
  bit active = 0;
  int t0 = 0, tdone = 0, ma = 0, mb = 0, eq = 0, er = 0;
  bit edz = 0;
  bit mlit = 0;
  int ml_q = 0, ml_r = 0, ml_lat = 0;
  bit ml_dz = 0;

  // literal expectations for the current directed case
  bit lit_valid = 0;
  int lit_q = 0, lit_r = 0, lit_lat = 0;
  bit lit_dz = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_control_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
    .in_mux_add(in_mux_add), .cu_const(cu_const), .we(we),
    .reg_add(reg_add), .out_mux_add(out_mux_add),
    .alu_op(alu_op), .alu_cin(alu_cin),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  // Datapath environment
  always_comb begin
    opa = bank[1];
    opb = bank[2];
    case (alu_op)
      PASS_A:  alu_out = opa;
      PASS_B:  alu_out = opb;
      ADD:     alu_out = opa + opb;
      SUB:     alu_out = opa - opb;
      SHL:     alu_out = {opa[6:0], alu_cin};
      INC:     alu_out = opa + 8'd1;
      default: alu_out = 8'h00;
    endcase
  end
  assign alu_n   = alu_out[7];
  assign alu_z   = (alu_out == 8'h00);
  assign alu_c   = opa[7];
  assign rd_port = bank[out_mux_add];

  always_comb begin
    case (in_mux_add)
      3'd0:    bank_din = in_a;
      3'd1:    bank_din = in_b;
      3'd2:    bank_din = cu_const;
      3'd3:    bank_din = alu_out;
      3'd4:    bank_din = rd_port;
      default: bank_din = 8'hxx;
    endcase
  end

  always @(posedge clk) if (we) bank[reg_add] <= bank_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Compare process: check this cycle, then advance the model with this cycle's inputs
  initial begin : compare
    bit seen_rst, rst_prev, exp_busy, exp_done;
    seen_rst = 0;
    rst_prev = 0;
    forever begin
      @(negedge clk);
      if (seen_rst) begin
        if (rst_prev)
          chk("reset_outputs",
              {5'd0, we, reg_add, in_mux_add, out_mux_add, cu_const, alu_op, alu_cin, busy, done, div_zero},
              {5'd0, 1'b0, 4'd15, 3'd0, 4'd0, 8'h00, PASS_A, 1'b0, 1'b0, 1'b0, 1'b0});
        exp_busy = active && (cyc > t0) && (cyc <= tdone);
        exp_done = active && (cyc == tdone);
        if (exp_done && mb == 0) edz = 1;
        chk("busy_done_dz", {29'd0, busy, done, div_zero}, {29'd0, exp_busy, exp_done, edz});
        if (!we) chk("park_addr", {28'd0, reg_add}, 32'd15);
        if (exp_done) begin
          chk("r3", {24'd0, bank[3]}, eq);
          chk("r7", {24'd0, bank[7]}, er);
          if (mlit) begin
            chk("pin_lat", tdone - t0, ml_lat);
            chk("pin_q", eq, ml_q);
            chk("pin_r", er, ml_r);
            chk("pin_dz", {31'd0, edz}, {31'd0, ml_dz});
          end
          $display("[TB] div %0d/%0d -> q=%0d r=%0d dz=%0d latency=%0d", ma, mb, bank[3], bank[7], div_zero, tdone - t0);
        end
      end
      if (rst) begin
        active = 0;
        edz = 0;
        seen_rst = 1;
      end else if (seen_rst && start && (!active || cyc > tdone)) begin
        active = 1;
        t0 = cyc;
        ma = int'(in_a);
        mb = int'(in_b);
        edz = 0;
        if (mb == 0) begin
          eq = 255; er = 0; tdone = t0 + 5;
        end else begin
          eq = ma / mb;
          er = ma % mb;
          // non-restoring leaves A negative exactly when the last quotient bit is 0
          tdone = t0 + ((eq % 2 == 0) ? 70 : 68);
        end
        mlit = lit_valid; ml_q = lit_q; ml_r = lit_r; ml_lat = lit_lat; ml_dz = lit_dz;
      end
      rst_prev = rst;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit lit,
                         input int lq, input int lr, input int llat, input bit ldz,
                         input bit pulses);
    in_a = a; in_b = b;
    lit_valid = lit; lit_q = lq; lit_r = lr; lit_lat = llat; lit_dz = ldz;
    start = 1;
    cycle();
    start = 0;
    while (cyc <= tdone) begin
      if (pulses) start = ($urandom_range(0, 7) == 0);
      cycle();
    end
    start = 0;
    cycle();
  endtask

  initial begin : stim
    int a, b;
    rst = 1; start = 0; in_a = 0; in_b = 0;
    repeat (3) cycle();
    rst = 0;
    cycle();

    run_div(8'd100, 8'd9,   1, 11,  1, 68, 0, 0);
    run_div(8'd100, 8'd7,   1, 14,  2, 70, 0, 0);
    run_div(8'd5,   8'd9,   1, 0,   5, 70, 0, 1);
    run_div(8'd255, 8'd127, 1, 2,   1, 70, 0, 1);
    run_div(8'd0,   8'd1,   1, 0,   0, 70, 0, 0);
    run_div(8'd42,  8'd0,   1, 255, 0, 5,  1, 0);
    run_div(8'd100, 8'd9,   1, 11,  1, 68, 0, 0);

    // start held high through DONE chains straight into a second division
    in_a = 8'd100; in_b = 8'd9;
    lit_valid = 1; lit_q = 11; lit_r = 1; lit_lat = 68; lit_dz = 0;
    start = 1;
    cycle();
    while (cyc <= tdone) cycle();
    cycle();
    while (cyc <= tdone) cycle();
    start = 0;
    cycle();

    // reset in the middle of iteration 4, then a clean division
    in_a = 8'd200; in_b = 8'd3; lit_valid = 0;
    start = 1;
    cycle();
    start = 0;
    while (cyc < t0 + 30) cycle();
    rst = 1;
    cycle();
    rst = 0;
    repeat (3) cycle();
    run_div(8'd100, 8'd9, 1, 11, 1, 68, 0, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      b = (i % 10 == 9) ? 0 : $urandom_range(0, 127);
      run_div(a[7:0], b[7:0], 0, 0, 0, 0, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
